// File: rtl/mux16_arb_pkg.sv
// rtl/mux16_arb_pkg.sv - shared widths and FSM state type for the 16-way round-robin arbiter
package mux16_arb_pkg;
  localparam int NUM_REQ = 16;
  localparam int SEL_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/mux16_rr_pick.sv
// rtl/mux16_rr_pick.sv - rotating-priority search: first set req bit at or above ptr, wrapping 15->0
module mux16_rr_pick
  import mux16_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[SEL_W'(int'(ptr) + i)]) begin
        found = 1'b1;
        idx   = SEL_W'(int'(ptr) + i);
      end
    end
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// rtl/mux16_rr_arbiter.sv - 16:1 mux with round-robin arbitration and hold quantum
// Optional owner lock (quantum extension) built when MUX16_ARB_LOCK_EN is defined.
module mux16_rr_arbiter
  import mux16_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
`ifdef MUX16_ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               y,
  output logic               valid
);

  localparam logic [3:0] HOLD_Q = 4'(HOLD_MAX);

  state_t           r_state;
  state_t           w_next_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  logic [3:0]       r_cnt;
  logic [SEL_W-1:0] w_sel_inc;
  logic [SEL_W-1:0] w_pick_ptr;
  logic [SEL_W-1:0] w_pick_idx;
  logic             w_found;
  logic             w_expire;
  logic             w_release;

  // While granted the search only matters at release, so it starts past the owner.
  assign w_sel_inc  = r_sel + 4'd1;
  assign w_pick_ptr = (r_state == GRANT) ? w_sel_inc : r_ptr;

  mux16_rr_pick u_pick (
    .req   (req),
    .ptr   (w_pick_ptr),
    .found (w_found),
    .idx   (w_pick_idx)
  );

`ifdef MUX16_ARB_LOCK_EN
  assign w_expire = (r_cnt == HOLD_Q) && !(lock && req[r_sel]);
`else
  assign w_expire = (r_cnt == HOLD_Q);
`endif
  assign w_release = !req[r_sel] || w_expire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_sel <= w_pick_idx;
            r_cnt <= 4'd1;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_ptr <= w_sel_inc;
            if (w_found) begin
              r_sel <= w_pick_idx;
              r_cnt <= 4'd1;
            end else begin
              r_cnt <= '0;
            end
          end else if (r_cnt != HOLD_Q) begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next_state = GRANT;
      GRANT:   if (w_release && !w_found) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    gnt   = '0;
    y     = 1'b0;
    if (r_state == GRANT) begin
      valid      = 1'b1;
      gnt[r_sel] = 1'b1;
      y          = din[r_sel];
    end
  end

  assign sel = r_sel;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb/tb_mux16_rr_arbiter.sv - directed scoreboard bench for mux16_rr_arbiter (MUX16_ARB_LOCK_EN optional)
module tb_mux16_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        lock;
  logic [15:0] req;
  logic [15:0] din;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        y;
  logic        valid;

  typedef struct {
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        valid;
    logic        y;
    logic        chk_sel;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mux16_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
`ifdef MUX16_ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .sel   (sel),
    .y     (y),
    .valid (valid)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic r, input logic [15:0] rq, input logic [15:0] d, input logic lk,
                      input logic [15:0] eg, input logic [3:0] es, input logic ev, input logic ey,
                      input logic cs, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    req   = rq;
    din   = d;
    lock  = lk;
    e.gnt = eg; e.sel = es; e.valid = ev; e.y = ey; e.chk_sel = cs; e.name = nm;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".gnt"}, gnt, e.gnt);
        if (e.chk_sel) chk({e.name, ".sel"}, {12'h0, sel}, {12'h0, e.sel});
        chk({e.name, ".valid"}, {15'h0, valid}, {15'h0, e.valid});
        chk({e.name, ".y"}, {15'h0, y}, {15'h0, e.y});
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0; req = '0; din = '0; lock = 1'b0;

    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 4'd0, 0, 0, 1, "reset0");
    step(0, 16'h0000, 16'h0000, 0, 16'h0000, 4'd0, 0, 0, 1, "reset1");
    step(1, 16'h0001, 16'h0001, 0, 16'h0001, 4'd0, 1, 1, 1, "first_grant");
    step(1, 16'h0000, 16'h0001, 0, 16'h0000, 4'd0, 0, 0, 0, "drop_to_idle");
    step(0, 16'h0000, 16'hAAAA, 0, 16'h0000, 4'd0, 0, 0, 1, "reset2");

    for (int c = 0; c < 68; c++)
      step(1, 16'hFFFF, 16'hAAAA, 0, 16'h0001 << ((c / 4) % 16), 4'((c / 4) % 16), 1,
           ((c / 4) % 2) == 1, 1, $sformatf("sweep%0d", c));

    step(1, 16'h8000, 16'hAAAA, 0, 16'h8000, 4'd15, 1, 1, 1, "owner15");
    step(1, 16'h0003, 16'hAAAA, 0, 16'h0001, 4'd0,  1, 0, 1, "wrap_to0");

    for (int c = 0; c < 10; c++)
      step(1, 16'h0020, 16'hAAAA, 0, 16'h0020, 4'd5, 1, 1, 1, $sformatf("single5_%0d", c));

    step(1, 16'h0080, 16'hAAAA, 0, 16'h0080, 4'd7, 1, 1, 1, "owner7");
    step(0, 16'h0080, 16'hAAAA, 0, 16'h0000, 4'd0, 0, 0, 1, "reset_mid");
    step(1, 16'h0180, 16'hAAAA, 0, 16'h0080, 4'd7, 1, 1, 1, "after_reset7");
    step(1, 16'h0181, 16'hAAAA, 0, 16'h0080, 4'd7, 1, 1, 1, "nonowner_add");
    step(1, 16'h0380, 16'hAAAA, 0, 16'h0080, 4'd7, 1, 1, 1, "nonowner_chg");
    step(1, 16'h0300, 16'hAAAA, 0, 16'h0100, 4'd8, 1, 0, 1, "owner8");
    step(1, 16'h0000, 16'hAAAA, 0, 16'h0000, 4'd0, 0, 0, 0, "idle_end");

`ifdef MUX16_ARB_LOCK_EN
    step(0, 16'h0000, 16'h0008, 0, 16'h0000, 4'd0, 0, 0, 1, "lk_reset");
    step(1, 16'h0008, 16'h0008, 0, 16'h0008, 4'd3, 1, 1, 1, "lk_owner3");
    for (int c = 0; c < 10; c++)
      step(1, 16'h0018, 16'h0008, 1, 16'h0008, 4'd3, 1, 1, 1, $sformatf("lk_hold%0d", c));
    step(1, 16'h0018, 16'h0008, 0, 16'h0010, 4'd4, 1, 0, 1, "lk_release4");
`endif

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux16_rr_arbiter.md
MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n; polarity and synchronicity are fixed.
REQ-002 Parameter HOLD_MAX, default 4: maximum consecutive grant cycles per owner, legal range 1..15.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-005 req  input  16  request vector; bit k = requester k wants the mux.
REQ-006 din  input  16  data bit per requester; bit k feeds mux input k.
REQ-007 lock  input  1  current owner asks to extend its grant (present only with MUX16_ARB_LOCK_EN).
REQ-008 gnt  output  16  one-hot grant; all-zero when idle.
REQ-009 sel  output  4  registered mux select, equal to the index of the set gnt bit.
REQ-010 y  output  1  din[sel] when valid=1, else 0 (combinational from registered sel).
REQ-011 valid  output  1  high while a grant is active.

Function
REQ-012 FSM states SHALL be IDLE and GRANT.
REQ-013 IDLE: if req!=0 at an edge, SHALL enter GRANT at that edge, owner = first set req bit searching upward from ptr with wrap 15->0; if req==0, stay IDLE.
REQ-014 Latency SHALL be exactly one cycle: req sampled at edge N -> gnt/sel/valid visible after edge N.
REQ-015 GRANT: hold counter SHALL start at 1 in the first grant cycle and increment each cycle the grant is held.
REQ-016 Release SHALL occur at the edge where req[owner]==0, or where counter==HOLD_MAX (quantum expiry).
REQ-017 On release, ptr SHALL become (owner+1) mod 16, wrapping 15->0.
REQ-018 On release with other requests pending, the next owner SHALL be chosen at the same edge from the new ptr, with no IDLE bubble; the releasing owner is searched last.
REQ-019 On release with no requests pending, SHALL return to IDLE with gnt=0, valid=0.
REQ-020 A single requester holding req continuously SHALL be re-granted after expiry at the same edge; the counter restarts at 1.
REQ-021 gnt SHALL never have more than one bit set; sel SHALL never change while valid=1 except at a release edge.
REQ-022 Changes to req on non-owner bits during GRANT SHALL NOT affect the current grant.

Reset
REQ-023 With rst_n=0 at an edge: state=IDLE, gnt=0, sel=0, valid=0, ptr=0, counter=0; y therefore 0.
REQ-024 Reset asserted mid-grant SHALL drop the grant at that edge; the first grant after reset searches from index 0.

Configuration
REQ-025 With MUX16_ARB_LOCK_EN defined: the lock port exists; quantum expiry is suppressed while lock=1 and req[owner]=1; the counter saturates at HOLD_MAX; deasserting req[owner] still releases.
REQ-026 Without MUX16_ARB_LOCK_EN: no lock port; release follows REQ-016 only.

Structure
REQ-027 Package mux16_arb_pkg SHALL hold NUM_REQ=16, SEL_W=4, and the FSM state enum (IDLE, GRANT).
REQ-028 The rotating-priority search SHALL be a sub-module mux16_rr_pick (inputs req and ptr; outputs found and idx), purely combinational.
REQ-029 The 16:1 data selection SHALL be inline in mux16_rr_arbiter.

Verification
REQ-030 Reset -> gnt=0, sel=0, valid=0, y=0; then req=16'h0001, din=16'h0001 -> after 1 edge gnt=16'h0001, sel=0, y=1.
REQ-031 req=16'hFFFF held, HOLD_MAX=4 -> owners 0,1,2,...,15,0 each for exactly 4 cycles, with no gap.
REQ-032 Owner 15 releases by dropping req[15], req=16'h0003 -> next gnt=16'h0001 (wrap), sel=0 at that same edge.
REQ-033 Single requester 5 held for 10 cycles -> grant held continuously; counter restarts at expiry; valid never drops.
REQ-034 rst_n=0 while owner=7 -> gnt=0 at that edge; after reset, req=16'h0180 -> owner 7 granted (search from 0).
REQ-035 With MUX16_ARB_LOCK_EN: owner 3 holds lock=1, req=16'h0018 for 10 cycles -> owner 3 is kept for all 10 cycles; lock=0 -> release at expiry; owner 4 granted.
